multi_channel_gain_corrector: RTL

//  Parametrised per-channel gain stage for AXI4-Stream video; successor to the fixed 3-channel white-balance multiplier.

---
 rtl/multi_channel_gain_corrector.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/multi_channel_gain_corrector.sv
// Per-channel unsigned fixed-point gain stage for AXI4-Stream video.
// Gains are latched into pending registers on gain_lock_i and become the
// applied gains only on an accepted start-of-frame beat, either by jumping
// or by ramping a bounded step per frame. Two-stage pipeline: multiply,
// then round-to-nearest with saturation.
module multi_channel_gain_corrector #(
  parameter int CH_NUM      = 3,
  parameter int PX_WIDTH    = 10,
  parameter int FRACT_WIDTH = 10,
  parameter int RAMP_STEP   = 64,
  localparam int GW          = PX_WIDTH + FRACT_WIDTH,
  localparam int TDATA_WIDTH = ((CH_NUM * PX_WIDTH + 7) / 8) * 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [CH_NUM*GW-1:0]   gain_target_i,
  input  logic                   gain_lock_i,
  input  logic                   ramp_en_i,
  input  logic                   bypass_i,
  output logic [CH_NUM*GW-1:0]   gain_cur_o,
  output logic                   ramp_busy_o,
  input  logic [TDATA_WIDTH-1:0] video_i_tdata,
  input  logic                   video_i_tvalid,
  output logic                   video_i_tready,
  input  logic                   video_i_tlast,
  input  logic                   video_i_tuser,
  output logic [TDATA_WIDTH-1:0] video_o_tdata,
  output logic                   video_o_tvalid,
  input  logic                   video_o_tready,
  output logic                   video_o_tlast,
  output logic                   video_o_tuser
);

  localparam int PW = PX_WIDTH + GW;
  localparam logic [GW-1:0] ONE    = GW'(64'd1 << FRACT_WIDTH);
  localparam logic [GW-1:0] STEP   = GW'(RAMP_STEP);
  localparam logic [PW:0]   HALF   = (PW+1)'(64'd1 << (FRACT_WIDTH - 1));
  localparam logic [PW:0]   PX_MAX = (PW+1)'((64'd1 << PX_WIDTH) - 64'd1);

  logic [GW-1:0]       pend_q  [CH_NUM];
  logic [GW-1:0]       app_q   [CH_NUM];
  logic [GW-1:0]       app_nxt [CH_NUM];
  logic [PW-1:0]       prod_c  [CH_NUM];
  logic [PW-1:0]       s1_prod [CH_NUM];
  logic [PX_WIDTH-1:0] s1_px   [CH_NUM];
  logic [PW:0]         rnd_c   [CH_NUM];
  logic [PW:0]         rsh_c   [CH_NUM];
  logic [TDATA_WIDTH-1:0] out_c;
  logic s1_valid, s1_byp, s1_last, s1_user;
  logic s1_ready, s2_ready, sof_acc, any_diff;
  logic unused_pad;

  // Padding bits of the input word carry no pixel data.
  assign unused_pad = ^video_i_tdata;

  assign s2_ready       = video_o_tready | ~video_o_tvalid;
  assign s1_ready       = s2_ready | ~s1_valid;
  assign video_i_tready = s1_ready;
  assign sof_acc        = video_i_tvalid & s1_ready & video_i_tuser;

  // Next applied gains: change only on an accepted SOF, jump or bounded ramp.
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      app_nxt[k] = app_q[k];
      if (sof_acc) begin
        if (!ramp_en_i) begin
          app_nxt[k] = pend_q[k];
        end else if (pend_q[k] > app_q[k]) begin
          app_nxt[k] = ((pend_q[k] - app_q[k]) > STEP) ? app_q[k] + STEP : pend_q[k];
        end else begin
          app_nxt[k] = ((app_q[k] - pend_q[k]) > STEP) ? app_q[k] - STEP : pend_q[k];
        end
      end
    end
  end

  // Busy compare and applied-gain output view.
  always_comb begin
    any_diff   = 1'b0;
    gain_cur_o = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (app_q[k] != pend_q[k]) any_diff = 1'b1;
      gain_cur_o[k*GW +: GW] = app_q[k];
    end
  end

  // Gain registers: pending loads on lock, applied follows app_nxt.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < CH_NUM; k++) begin
        pend_q[k] <= ONE;
        app_q[k]  <= ONE;
      end
      ramp_busy_o <= 1'b0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        app_q[k] <= app_nxt[k];
        if (gain_lock_i) pend_q[k] <= gain_target_i[k*GW +: GW];
      end
      ramp_busy_o <= any_diff;
    end
  end

  // Stage-1 products use app_nxt so the SOF pixel sees its own frame's gain.
  always_comb begin
    for (int k = 0; k < CH_NUM; k++) begin
      prod_c[k] = PW'(video_i_tdata[k*PX_WIDTH +: PX_WIDTH]) * PW'(app_nxt[k]);
    end
  end

  // Stage 1 register: products, raw pixels for bypass, sideband bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_byp   <= 1'b0;
      s1_last  <= 1'b0;
      s1_user  <= 1'b0;
      for (int k = 0; k < CH_NUM; k++) begin
        s1_prod[k] <= '0;
        s1_px[k]   <= '0;
      end
    end else if (s1_ready) begin
      s1_valid <= video_i_tvalid;
      if (video_i_tvalid) begin
        s1_byp  <= bypass_i;
        s1_last <= video_i_tlast;
        s1_user <= video_i_tuser;
        for (int k = 0; k < CH_NUM; k++) begin
          s1_prod[k] <= prod_c[k];
          s1_px[k]   <= video_i_tdata[k*PX_WIDTH +: PX_WIDTH];
        end
      end
    end
  end

  // Round to nearest, saturate to the pixel range, or pass through on bypass.
  always_comb begin
    out_c = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      rnd_c[k] = {1'b0, s1_prod[k]} + HALF;
      rsh_c[k] = rnd_c[k] >> FRACT_WIDTH;
      if (s1_byp)
        out_c[k*PX_WIDTH +: PX_WIDTH] = s1_px[k];
      else if (rsh_c[k] > PX_MAX)
        out_c[k*PX_WIDTH +: PX_WIDTH] = {PX_WIDTH{1'b1}};
      else
        out_c[k*PX_WIDTH +: PX_WIDTH] = rsh_c[k][PX_WIDTH-1:0];
    end
  end

  // Stage 2 register drives the output stream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      video_o_tvalid <= 1'b0;
      video_o_tdata  <= '0;
      video_o_tlast  <= 1'b0;
      video_o_tuser  <= 1'b0;
    end else if (s2_ready) begin
      video_o_tvalid <= s1_valid;
      if (s1_valid) begin
        video_o_tdata <= out_c;
        video_o_tlast <= s1_last;
        video_o_tuser <= s1_user;
      end
    end
  end

endmodule
